// File: rtl/codificador_sequencial.sv
// Sequential priority encoder: captures a multi-hot request vector and hands out
// one binary index per set bit, highest first, over a valid/ready handshake.
module codificador_sequencial #(
    parameter int LARG_IN  = 8,
    parameter int LARG_OUT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LARG_IN-1:0]  A,
    input  logic                E,
    output logic                in_ready,
    output logic [LARG_OUT-1:0] S,
    output logic                V,
    input  logic                out_ready,
    output logic                last,
    output logic [LARG_OUT:0]   qtd,
    output logic                vazio
);

    // Handshake: an index moves at a rising edge where V and out_ready are both
    // high; while out_ready is low, S/V/last/qtd hold and nothing is dropped.
    typedef enum logic {IDLE = 1'b0, DRENO = 1'b1} estado_t;

    estado_t              state, state_n;
    logic [LARG_IN-1:0]   pend, pend_n;
    logic                 vazio_r, vazio_n;
    logic [LARG_OUT-1:0]  idx;
    logic [LARG_OUT:0]    cnt;

    // Highest set bit and population count of the pending requests.
    always_comb begin
        idx = '0;
        cnt = '0;
        for (int i = 0; i < LARG_IN; i++) begin
            if (pend[i]) begin
                idx = i[LARG_OUT-1:0];
            end
            cnt = cnt + {{LARG_OUT{1'b0}}, pend[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= '0;
            vazio_r <= 1'b0;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            vazio_r <= vazio_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        vazio_n = 1'b0;
        case (state)
            IDLE: begin
                if (E) begin
                    if (A != '0) begin
                        pend_n  = A;
                        state_n = DRENO;
                    end else begin
                        vazio_n = 1'b1;
                    end
                end
            end
            DRENO: begin
                if (out_ready) begin
                    pend_n[idx] = 1'b0;
                    if (cnt == {{LARG_OUT{1'b0}}, 1'b1}) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        V        = (state == DRENO);
        S        = V ? idx : '0;
        qtd      = V ? cnt : '0;
        last     = V && (cnt == {{LARG_OUT{1'b0}}, 1'b1});
        vazio    = vazio_r;
    end

endmodule

// File: tb/tb_codificador_sequencial.sv
// Bench for codificador_sequencial: queue-of-indices reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_codificador_sequencial;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic       E;
    logic       in_ready;
    logic [2:0] S;
    logic       V;
    logic       out_ready;
    logic       last;
    logic [3:0] qtd;
    logic       vazio;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    int m_q[$];
    bit m_vazio = 0;

    codificador_sequencial #(.LARG_IN(8), .LARG_OUT(3)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .E(E), .in_ready(in_ready),
        .S(S), .V(V), .out_ready(out_ready), .last(last), .qtd(qtd), .vazio(vazio)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending indices held as a descending list.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_vazio = 0;
        end else begin
            m_vazio = 0;
            if (m_q.size() == 0) begin
                if (E) begin
                    if (A == 8'h00) m_vazio = 1;
                    else for (int i = 7; i >= 0; i--) if (A[i]) m_q.push_back(i);
                end
            end else if (out_ready) begin
                void'(m_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = m_q.size();
            check("m_in_ready", in_ready, (n == 0));
            check("m_V", V, (n != 0));
            check("m_S", S, (n != 0) ? m_q[0] : 0);
            check("m_qtd", qtd, n);
            check("m_last", last, (n == 1));
            check("m_vazio", vazio, m_vazio);
        end
    end

    task automatic capture(input logic [7:0] a);
        A = a;
        E = 1;
        @(negedge clk);
        E = 0;
    endtask

    initial begin
        rst_n = 0; E = 0; A = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("rst_in_ready", in_ready, 1);
        check("rst_V", V, 0);
        check("rst_S", S, 0);
        check("rst_qtd", qtd, 0);
        check("rst_last", last, 0);
        check("rst_vazio", vazio, 0);
        rst_n = 1;
        @(negedge clk);

        // Sparse vector
        out_ready = 1;
        capture(8'b1010_0100);
        check("sp_S7", S, 7); check("sp_q3", qtd, 3); check("sp_l0", last, 0);
        @(negedge clk);
        check("sp_S5", S, 5); check("sp_q2", qtd, 2);
        @(negedge clk);
        check("sp_S2", S, 2); check("sp_q1", qtd, 1); check("sp_l1", last, 1);
        @(negedge clk);
        check("sp_idle", in_ready, 1); check("sp_V0", V, 0);

        // Empty capture
        out_ready = 0;
        capture(8'h00);
        check("em_vazio1", vazio, 1); check("em_V", V, 0); check("em_rdy", in_ready, 1);
        @(negedge clk);
        check("em_vazio0", vazio, 0);

        // Backpressure
        capture(8'h81);
        repeat (5) begin
            check("bp_S", S, 7); check("bp_V", V, 1); check("bp_q", qtd, 2); check("bp_l", last, 0);
            @(negedge clk);
        end
        out_ready = 1;
        check("bp_S7", S, 7);
        @(negedge clk);
        check("bp_S0", S, 0); check("bp_last", last, 1);
        @(negedge clk);
        check("bp_idle", in_ready, 1);
        out_ready = 0;

        // Capture ignored while busy
        capture(8'h11);
        check("bz_S4", S, 4);
        capture(8'hFF);
        check("bz_S4b", S, 4); check("bz_q2", qtd, 2);
        out_ready = 1;
        @(negedge clk);
        check("bz_S0", S, 0); check("bz_last", last, 1);
        @(negedge clk);
        check("bz_idle", in_ready, 1); check("bz_V0", V, 0);

        // Full vector then back-to-back capture
        capture(8'hFF);
        for (int i = 7; i >= 0; i--) begin
            check("fv_S", S, i); check("fv_q", qtd, i + 1); check("fv_l", last, (i == 0));
            @(negedge clk);
        end
        check("fv_idle", in_ready, 1);
        capture(8'h02);
        check("b2b_S1", S, 1); check("b2b_last", last, 1);
        @(negedge clk);
        check("b2b_idle", in_ready, 1);

        // Reset mid-operation
        capture(8'hFF);
        @(negedge clk);
        @(negedge clk);
        check("mr_S5", S, 5);
        rst_n = 0; out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        check("mr_V", V, 0); check("mr_S", S, 0); check("mr_q", qtd, 0);
        check("mr_l", last, 0); check("mr_rdy", in_ready, 1);
        rst_n = 1;
        @(negedge clk);
        check("mr_stay", V, 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 60) != 0);
            E         = ($urandom_range(0, 2) == 0);
            A         = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
